// File: rtl/audio_pkg.sv
// Audio constants shared by the transmit and receive paths, plus the peak-level helper.
`timescale 1ns/1ps
package audio_pkg;

    localparam int unsigned SAMPLE_W           = 16;
    localparam logic [SAMPLE_W-1:0] SAMPLE_ZERO = 16'h8000;
    localparam int unsigned DECIM_LOG2_DEFAULT = 9;
    localparam int unsigned DECAY_LOG2_DEFAULT = 4;

    // Magnitude around mid-scale and the resulting level code
    localparam int unsigned MAG_W   = SAMPLE_W - 1;
    localparam int unsigned LEVEL_W = 4;

    // Startup phases: outputs are suppressed until three comb results have flushed
    typedef enum logic [1:0] {
        WARM_0   = 2'd0,
        WARM_1   = 2'd1,
        WARM_2   = 2'd2,
        WARM_RUN = 2'd3
    } warm_state_e;

    // floor(log2(mag)) + 1, or 0 for a zero magnitude; tops out at 15 for a 15-bit input
    function automatic logic [LEVEL_W-1:0] level_code(input logic [MAG_W-1:0] mag);
        logic [LEVEL_W-1:0] code;
        code = '0;
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (mag[4'(i)]) begin
                code = LEVEL_W'(i + 1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/level_meter.sv
// Peak-hold level meter: log2 magnitude of each valid sample with slow decay.
`timescale 1ns/1ps
module level_meter
    import audio_pkg::*;
#(
    parameter int unsigned DECAY_LOG2 = DECAY_LOG2_DEFAULT
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic [LEVEL_W-1:0]  level
);

    logic [MAG_W-1:0]      mag_c;
    logic [LEVEL_W-1:0]    new_level_c;
    logic [DECAY_LOG2-1:0] decay_cnt;

    // Distance from mid-scale kept to 15 bits; the single code 0x0000 aliases to 0
    always_comb begin
        mag_c       = '0;
        new_level_c = '0;
        if (sample[SAMPLE_W-1]) begin
            mag_c = sample[MAG_W-1:0];
        end else begin
            mag_c = MAG_W'(SAMPLE_ZERO - sample);
        end
        new_level_c = level_code(mag_c);
    end

    // Peak hold: a louder sample reloads at once, otherwise step down once per decay wrap
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            level     <= '0;
            decay_cnt <= '0;
        end else if (sample_valid) begin
            if (new_level_c > level) begin
                level     <= new_level_c;
                decay_cnt <= '0;
            end else begin
                decay_cnt <= decay_cnt + DECAY_LOG2'(1);
                if ((decay_cnt == '1) && (level != '0)) begin
                    level <= level - LEVEL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator turning the 1-bit PDM stream back into 16-bit offset-binary samples.
`timescale 1ns/1ps
module pdm_decimator
    import audio_pkg::*;
#(
    parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEFAULT,
    parameter int unsigned DECAY_LOG2 = DECAY_LOG2_DEFAULT
) (
    input  logic                clk48,
    input  logic                rst_n,
    input  logic                pdm_in,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic [LEVEL_W-1:0]  level
);

    // Bit growth of a 3rd-order CIC is 3*log2(R); one extra bit holds exact full scale
    localparam int unsigned FS_BIT   = 3 * DECIM_LOG2;
    localparam int unsigned W        = FS_BIT + 1;
    localparam int unsigned SLICE_LO = FS_BIT - SAMPLE_W;

    logic [W-1:0]            int1;
    logic [W-1:0]            int2;
    logic [W-1:0]            int3;
    logic [DECIM_LOG2-1:0]   ph;
    logic                    strike_c;

    logic [W-1:0]            d0;
    logic [W-1:0]            d0_prev;
    logic [W-1:0]            c1;
    logic [W-1:0]            c1_prev;
    logic [W-1:0]            c2;
    logic [W-1:0]            c2_prev;
    logic                    d0_vld;
    logic                    c1_vld;
    logic                    c2_vld;

    logic [W-1:0]            c3_c;
    logic [SAMPLE_W:0]       c3_top_c;
    logic [SAMPLE_W-1:0]     sample_next_c;

    warm_state_e             warm_state;
    warm_state_e             warm_next;
    logic                    out_en_c;

    // Integrator chain, free-running modulo 2^W
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
        end else begin
            int1 <= int1 + W'(pdm_in);
            int2 <= int2 + int1;
            int3 <= int3 + int2;
        end
    end

    // Decimation phase; the last phase of each period is the strike
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
        end else begin
            ph <= ph + DECIM_LOG2'(1);
        end
    end

    assign strike_c = (ph == '1);

    // Comb pipeline: each stage and its history register advance only behind a strike
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            d0      <= '0;
            d0_prev <= '0;
            c1      <= '0;
            c1_prev <= '0;
            c2      <= '0;
            c2_prev <= '0;
            d0_vld  <= 1'b0;
            c1_vld  <= 1'b0;
            c2_vld  <= 1'b0;
        end else begin
            d0_vld <= strike_c;
            c1_vld <= d0_vld;
            c2_vld <= c1_vld;
            if (strike_c) begin
                d0      <= int3;
                d0_prev <= d0;
            end
            if (d0_vld) begin
                c1      <= d0 - d0_prev;
                c1_prev <= c1;
            end
            if (c1_vld) begin
                c2      <= c1 - c1_prev;
                c2_prev <= c2;
            end
        end
    end

    // Last comb stage and scaling: bit W-1 set means at or beyond full scale
    always_comb begin
        c3_c          = '0;
        c3_top_c      = '0;
        sample_next_c = '0;
        c3_c          = c2 - c2_prev;
        c3_top_c      = (SAMPLE_W + 1)'(c3_c >> SLICE_LO);
        if (c3_top_c[SAMPLE_W]) begin
            sample_next_c = '1;
        end else begin
            sample_next_c = c3_top_c[SAMPLE_W-1:0];
        end
    end

    // Output register; the sample is written during warm-up, only the strobe is held back
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= c2_vld && out_en_c;
            if (c2_vld) begin
                sample <= sample_next_c;
            end
        end
    end

    // Warm-up state register
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            warm_state <= WARM_0;
        end else begin
            warm_state <= warm_next;
        end
    end

    // Warm-up next state: one step per comb result until running
    always_comb begin
        warm_next = warm_state;
        if (c2_vld) begin
            case (warm_state)
                WARM_0:   warm_next = WARM_1;
                WARM_1:   warm_next = WARM_2;
                WARM_2:   warm_next = WARM_RUN;
                WARM_RUN: warm_next = WARM_RUN;
                default:  warm_next = WARM_0;
            endcase
        end
    end

    // Warm-up output decode
    always_comb begin
        out_en_c = 1'b0;
        if (warm_state == WARM_RUN) begin
            out_en_c = 1'b1;
        end
    end

    level_meter #(
        .DECAY_LOG2 (DECAY_LOG2)
    ) u_level_meter (
        .clk48        (clk48),
        .rst_n        (rst_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .level        (level)
    );

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: direct-form CIC and peak-hold reference feeding a scoreboard.
`timescale 1ns/1ps
module tb_pdm_decimator;

    localparam int DL    = 9;
    localparam int R     = 512;
    localparam int FSB   = 3 * DL;
    localparam int HLEN  = 3 * R - 2;

    typedef struct {
        logic [15:0] s;
        logic [3:0]  lv;
    } exp_t;

    logic        clk48 = 1'b0;
    logic        rst_n = 1'b0;
    logic        pdm_in;
    logic [15:0] sample;
    logic        sample_valid;
    logic [3:0]  level;

    int total = 0;
    int bad   = 0;

    // reference state
    longint h [HLEN];
    bit     hist [$];
    exp_t   sb [$];
    int     edge_n;
    int     strikes;
    int     lvl_m;
    int     dcnt_m;

    // stimulus state
    int          mode = 0;
    logic [15:0] sd_target = 16'h0000;
    logic [16:0] sd_acc = 17'd0;
    bit          alt = 1'b0;

    pdm_decimator #(
        .DECIM_LOG2 (DL),
        .DECAY_LOG2 (4)
    ) dut (
        .clk48        (clk48),
        .rst_n        (rst_n),
        .pdm_in       (pdm_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .level        (level)
    );

    always #5 clk48 = ~clk48;

    // Impulse response of three cascaded length-R boxcars
    task automatic build_h();
        longint h2 [2*R-1];
        longint acc;
        int lo;
        int hi;
        for (int k = 0; k < 2*R-1; k++) h2[k] = (k < R) ? longint'(k + 1) : longint'(2*R - 1 - k);
        for (int k = 0; k < HLEN; k++) begin
            acc = 0;
            lo = (k - R + 1 > 0) ? k - R + 1 : 0;
            hi = (k < 2*R-2) ? k : 2*R-2;
            for (int j = lo; j <= hi; j++) acc += h2[j];
            h[k] = acc;
        end
    endtask

    // Reference output for the strike at edge e, plus the reference level after it
    task automatic model_strike(input int e);
        longint y;
        int n;
        int a;
        int nw;
        exp_t x;
        y = 0;
        n = e - 3;
        for (int k = 0; k < HLEN; k++) begin
            if ((n - k >= 0) && hist[n - k]) y += h[k];
        end
        strikes++;
        if (strikes >= 4) begin
            if (y >= (longint'(1) << FSB)) x.s = 16'hFFFF;
            else x.s = 16'(y >> (FSB - 16));
            if (int'(x.s) >= 32768) a = int'(x.s) - 32768;
            else a = (32768 - int'(x.s)) % 32768;
            nw = 0;
            for (int b = 0; b < 15; b++) if (((a >> b) & 1) == 1) nw = b + 1;
            if (nw > lvl_m) begin
                lvl_m  = nw;
                dcnt_m = 0;
            end else begin
                if ((dcnt_m == 15) && (lvl_m > 0)) lvl_m = lvl_m - 1;
                dcnt_m = (dcnt_m + 1) % 16;
            end
            x.lv = 4'(lvl_m);
            sb.push_back(x);
        end
    endtask

    // Record every sampled PDM bit and run the reference at each strike
    always @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            sb.delete();
            edge_n  = 0;
            strikes = 0;
            lvl_m   = 0;
            dcnt_m  = 0;
        end else begin
            hist.push_back(pdm_in);
            if ((edge_n % R) == R - 1) model_strike(edge_n);
            edge_n++;
        end
    end

    // PDM source: constant, alternating, or first-order sigma-delta
    initial begin
        pdm_in = 1'b0;
        forever begin
            @(negedge clk48);
            case (mode)
                0: pdm_in = 1'b0;
                1: pdm_in = 1'b1;
                2: begin alt = ~alt; pdm_in = alt; end
                default: begin
                    sd_acc = {1'b0, sd_acc[15:0]} + {1'b0, sd_target};
                    pdm_in = sd_acc[16];
                end
            endcase
        end
    end

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk48);
            if (sample_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        mode  = 0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk48);
        total++; if (sample !== 16'h0000) begin bad++; $display("FAIL reset_sample got=%h exp=0000", sample); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        bit got;
        exp_t e;
        mode = 0;
        for (int i = 0; i < 18; i++) begin
            wait_valid((i == 0) ? 2600 : 1200, got);
            total++;
            if (!got || sb.size() == 0) begin bad++; $display("FAIL zero_timeout idx=%0d", i); return; end
            e = sb.pop_front();
            if (sample !== e.s || sample !== 16'h0000) begin
                bad++; $display("FAIL zero_sample idx=%0d got=%h model=%h exp=0000", i, sample, e.s);
            end
            @(negedge clk48);
            total++;
            if (level !== e.lv || level !== 4'd0) begin
                bad++; $display("FAIL zero_level idx=%0d got=%0d model=%0d exp=0", i, level, e.lv);
            end
        end
    endtask

    task automatic test_ones();
        bit got;
        exp_t e;
        mode = 1;
        for (int i = 0; i < 8; i++) begin
            wait_valid(1200, got);
            total++;
            if (!got || sb.size() == 0) begin bad++; $display("FAIL ones_timeout idx=%0d", i); return; end
            e = sb.pop_front();
            if (sample !== e.s) begin bad++; $display("FAIL ones_sample idx=%0d got=%h exp=%h", i, sample, e.s); end
            if (i >= 3) begin
                total++;
                if (sample !== 16'hFFFF) begin bad++; $display("FAIL ones_sat idx=%0d got=%h exp=ffff", i, sample); end
            end
            @(negedge clk48);
            total++;
            if (level !== e.lv) begin bad++; $display("FAIL ones_level idx=%0d got=%0d exp=%0d", i, level, e.lv); end
            if (i >= 3) begin
                total++;
                if (level !== 4'd15) begin bad++; $display("FAIL ones_level15 idx=%0d got=%0d exp=15", i, level); end
            end
        end
    endtask

    task automatic test_decay();
        bit got;
        exp_t e;
        int lv_exp;
        mode = 2;
        for (int i = 0; i < 50; i++) begin
            wait_valid(1200, got);
            total++;
            if (!got || sb.size() == 0) begin bad++; $display("FAIL decay_timeout idx=%0d", i); return; end
            e = sb.pop_front();
            if (sample !== e.s) begin bad++; $display("FAIL decay_sample idx=%0d got=%h exp=%h", i, sample, e.s); end
            if (i >= 3) begin
                total++;
                if (sample !== 16'h8000) begin bad++; $display("FAIL decay_mid idx=%0d got=%h exp=8000", i, sample); end
            end
            @(negedge clk48);
            total++;
            if (level !== e.lv) begin bad++; $display("FAIL decay_level idx=%0d got=%0d exp=%0d", i, level, e.lv); end
            lv_exp = (i < 8) ? 15 : (i < 24) ? 14 : (i < 40) ? 13 : 12;
            if (i == 7 || i == 8 || i == 24 || i == 40 || i == 49) begin
                total++;
                if (level !== 4'(lv_exp)) begin bad++; $display("FAIL decay_step idx=%0d got=%0d exp=%0d", i, level, lv_exp); end
            end
        end
        mode = 1;
        for (int i = 0; i < 2; i++) begin
            wait_valid(1200, got);
            total++;
            if (!got || sb.size() == 0) begin bad++; $display("FAIL burst_timeout idx=%0d", i); return; end
            e = sb.pop_front();
            if (sample !== e.s) begin bad++; $display("FAIL burst_sample idx=%0d got=%h exp=%h", i, sample, e.s); end
            @(negedge clk48);
            total++;
            if (level !== e.lv) begin bad++; $display("FAIL burst_level idx=%0d got=%0d exp=%0d", i, level, e.lv); end
            if (i == 1) begin
                total++;
                if (level !== 4'd15) begin bad++; $display("FAIL burst_reload got=%0d exp=15", level); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        exp_t e;
        int gap;
        wait_valid(1200, got);
        total++;
        if (!got || sb.size() == 0) begin bad++; $display("FAIL btb_timeout first"); return; end
        e = sb.pop_front();
        if (sample !== e.s) begin bad++; $display("FAIL btb_sample idx=0 got=%h exp=%h", sample, e.s); end
        for (int i = 1; i < 4; i++) begin
            gap = 0;
            got = 1'b0;
            while (!got && gap < 1200) begin
                @(negedge clk48);
                gap++;
                if (gap == 1) begin
                    total++;
                    if (sample_valid !== 1'b0) begin bad++; $display("FAIL btb_consecutive idx=%0d got=%b exp=0", i, sample_valid); end
                end
                if (sample_valid === 1'b1) got = 1'b1;
            end
            total++;
            if (gap != R) begin bad++; $display("FAIL btb_gap idx=%0d got=%0d exp=%0d", i, gap, R); end
            if (!got || sb.size() == 0) begin bad++; $display("FAIL btb_timeout idx=%0d", i); return; end
            e = sb.pop_front();
            total++;
            if (sample !== e.s) begin bad++; $display("FAIL btb_sample idx=%0d got=%h exp=%h", i, sample, e.s); end
        end
    endtask

    task automatic test_sd(input logic [15:0] target);
        bit got;
        exp_t e;
        int diff;
        mode      = 3;
        sd_target = target;
        sd_acc    = 17'd0;
        for (int i = 0; i < 8; i++) begin
            wait_valid(1200, got);
            total++;
            if (!got || sb.size() == 0) begin bad++; $display("FAIL sd_timeout tgt=%h idx=%0d", target, i); return; end
            e = sb.pop_front();
            if (sample !== e.s) begin bad++; $display("FAIL sd_sample tgt=%h idx=%0d got=%h exp=%h", target, i, sample, e.s); end
            if (i >= 3) begin
                diff = int'(sample) - int'(target);
                total++;
                if (diff > 2 || diff < -2) begin
                    bad++; $display("FAIL sd_tol tgt=%h idx=%0d got=%h exp=%h+-2", target, i, sample, target);
                end
            end
            @(negedge clk48);
            total++;
            if (level !== e.lv) begin bad++; $display("FAIL sd_level tgt=%h idx=%0d got=%0d exp=%0d", target, i, level, e.lv); end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        exp_t e;
        int c;
        wait_valid(1200, got);
        total++;
        if (!got) begin bad++; $display("FAIL rmid_timeout pre"); return; end
        repeat (97) @(posedge clk48);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (sample !== 16'h0000) begin bad++; $display("FAIL rmid_sample got=%h exp=0000", sample); end
        total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", sample_valid); end
        total++; if (level !== 4'd0) begin bad++; $display("FAIL rmid_level got=%0d exp=0", level); end
        mode = 2;
        repeat (3) @(negedge clk48);
        rst_n = 1'b1;
        c = 0;
        got = 1'b0;
        while (!got && c < 3000) begin
            @(negedge clk48);
            if (sample_valid === 1'b1) got = 1'b1;
            else c++;
        end
        total++;
        if (c != 4 * R + 2) begin bad++; $display("FAIL rmid_first_valid got=%0d exp=%0d", c, 4 * R + 2); end
        if (!got || sb.size() == 0) begin bad++; $display("FAIL rmid_timeout post"); return; end
        e = sb.pop_front();
        total++;
        if (sample !== e.s || sample !== 16'h8000) begin
            bad++; $display("FAIL rmid_alt_sample got=%h model=%h exp=8000", sample, e.s);
        end
        @(negedge clk48);
        total++;
        if (level !== e.lv || level !== 4'd0) begin
            bad++; $display("FAIL rmid_alt_level got=%0d model=%0d exp=0", level, e.lv);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        build_h();
        test_reset();
        test_zero();
        test_ones();
        test_decay();
        test_back_to_back();
        test_sd(16'h4000);
        test_sd(16'hC000);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Receive-side counterpart to the 1-bit sigma-delta audio output. The block takes the PDM bitstream at `clk48` rate and reconstructs 16-bit offset-binary samples with a 3rd-order CIC decimator, one sample per 2^DECIM_LOG2 clocks. It also produces a 4-bit peak-hold level for the visual side. Uses: loopback self-check of the audio path, and driving audio-reactive effects from the same stream the speaker hears.

## Interface
- `DECIM_LOG2`, default 9: log2 of the decimation ratio R (512 clocks per sample).
- `DECAY_LOG2`, default 4: the peak level decays by 1 every 2^DECAY_LOG2 output samples.
- `clk48`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pdm_in`  in  1  PDM bit, sampled every `clk48`. 1 counts as +1, 0 counts as 0.
- `sample`  out  16  reconstructed sample, offset binary (0x8000 = zero).
- `sample_valid`  out  1  one-cycle strobe; `sample` is updated on the same edge.
- `level`  out  4  peak-hold magnitude level, 0..15.

## Operation
- W = 3·DECIM_LOG2 + 1 (28 at default). All integrator and comb arithmetic is unsigned W-bit, modulo 2^W. Wrap-around is intended and must not be saturated.
- Integrators I1, I2, I3 update every clock:
  - I1 += pdm_in
  - I2 += I1
  - I3 += I2
- Phase counter `ph`, DECIM_LOG2 bits, free-running from 0 after reset.
  - On the edge where `ph` = 2^DECIM_LOG2−1, snapshot I3 into D0. That edge is the "strike".
- Comb pipeline, one stage per clock:
  - C1 = D0 − D0prev
  - C2 = C1 − C1prev
  - C3 = C2 − C2prev
  - Each `prev` register updates only when its stage advances.
- Output scaling: full scale is 2^(3·DECIM_LOG2).
  - If C3[W−1] is set, `sample` = 0xFFFF (saturate).
  - Otherwise `sample` = C3[3·DECIM_LOG2−1 : 3·DECIM_LOG2−16] (truncate).
- Warm-up: a 2-bit counter suppresses `sample_valid` for the first 3 strikes after reset. `sample` is still written during warm-up.
- Level meter:
  - a = |sample − 0x8000|, 15 bits.
  - new = 0 if a = 0, else floor(log2 a) + 1, clipped to 15.
  - On each valid sample: if new > `level`, load new and clear the decay counter. Otherwise increment the decay counter; when it wraps, decrement `level`, saturating at 0.
  - When rise and decay coincide, rise wins.

## Timing
- Reset values: `sample` = 0x0000, `sample_valid` = 0, `level` = 0. Integrators, combs, `ph`, warm-up counter and decay counter are all 0.
- Latency: the strike at edge T gives C1 at T+1, C2 at T+2, and `sample` plus `sample_valid` at T+3.
- `level` updates at T+4, one cycle after `sample_valid`.
- `sample_valid` is high exactly one cycle per 2^DECIM_LOG2 clocks and never on consecutive cycles.
- The first valid strobe is at clock 4·2^DECIM_LOG2 + 2 after reset release, counting clock 0 as the first edge with `ph` = 0.
- Reset asserted mid-operation clears every register immediately, including an in-flight comb pipeline. The warm-up restarts after release.
- No handshake: consumers must capture on the strobe. No backpressure.

## Structure
- The shared `audio_pkg` holds SAMPLE_W = 16, SAMPLE_ZERO = 16'h8000 and the default DECIM_LOG2 = 9. The transmit side must use the same constants.
- W and the slice indices are localparams derived inside the block.
- Sub-module: `level_meter` (sample, sample_valid → level) holds the log2/abs logic and peak-hold/decay. It can be reused on other sample streams.

## Test plan
- `pdm_in` held 0 → after warm-up, every valid gives `sample` = 0x0000 and `level` = 0.
- `pdm_in` held 1 → `sample` = 0xFFFF (saturated, C3 = 2^27), `level` = 15.
- `pdm_in` alternating 1,0 → `sample` = 0x8000 exactly, `level` = 0.
- A bench first-order sigma-delta modulator driven with constant 0x4000 → `sample` within 0x4000 ±2 LSB from the 4th valid onward. Repeat with 0xC000.
- Level decay: drive full-scale for 8 samples, then switch to the 1,0 pattern → `level` holds 15, then drops by 1 every 16 valids down to 0. A louder burst mid-decay reloads immediately.
- Reset pulse 100 clocks into a decimation period → all outputs 0 within the same cycle. First valid after release occurs at exactly 4·512 + 2 clocks.
